axi_write_slave: RTL and testbench
==================================

# axi_write_slave

AXI write-side responder placed at each memory-mapped slave port of the interconnect, such as the IM/DM SRAM wrappers. It accepts one write address (AW), then the matching burst of write data (W), and drives the word-addressed SRAM write port. It then returns the write response (B) whose BID, BRESP and BVALID feed the interconnect's write-response router. Only one transaction is outstanding at a time; there is no write interleaving.

## Interface
- ADDR_W, 14: SRAM word-address width.
- IDS_W, 8: slave-side ID width (`AXI_IDS_BITS`). Bits [5:4] carry the master tag and [3:0] carry the master ID.
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- AWID  in  IDS_W  write address ID
- AWADDR  in  32  byte address (bits [1:0] ignored)
- AWLEN  in  4  beats minus one
- AWSIZE  in  3  only 3'b010 legal
- AWBURST  in  2  2'b00 FIXED, 2'b01 INCR, others treated as INCR
- AWVALID / AWREADY  in / out  1  AW handshake
- WDATA  in  32  write data
- WSTRB  in  4  byte strobes, 1 = write byte
- WLAST  in  1  final beat marker
- WVALID / WREADY  in / out  1  W handshake
- BID  out  IDS_W  response ID, equals latched AWID
- BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
- BVALID / BREADY  out / in  1  B handshake
- mem_we  out  1  SRAM write enable, active-high, one cycle per beat
- mem_addr  out  ADDR_W  SRAM word address
- mem_wstrb  out  4  byte enables (= WSTRB)
- mem_wdata  out  32  write data (= WDATA)

## Operation
- FSM states: IDLE, DATA, RESP. Reset enters IDLE.
- **IDLE**
  - AWREADY=1; WREADY=0; BVALID=0.
  - On AWVALID&AWREADY: latch AWID, word address AWADDR[ADDR_W+1:2], AWLEN, AWBURST.
  - Clear the beat counter (4-bit) and the error flag.
  - Go to DATA.
- **DATA**
  - WREADY=1; AWREADY=0.
  - Each W handshake asserts mem_we combinationally in that cycle with mem_addr = current word address.
  - After each beat: counter+1. INCR adds 1 to the address, wrapping modulo 2^ADDR_W. FIXED holds the address.
  - Burst ends on whichever comes first: WLAST=1, or the beat where counter==AWLEN.
  - Error flag is set if WLAST and (counter==AWLEN) disagree on the terminating beat, or if AWSIZE!=3'b010 was latched.
  - The terminating beat is still written; any later W beats belong to no transaction and wait (WREADY=0).
  - Go to RESP.
- **RESP**
  - BVALID=1; BID=latched AWID; BRESP = error ? 2'b10 : 2'b00.
  - BID/BRESP stay stable while BVALID=1 and BREADY=0.
  - On BREADY: go to IDLE.
- mem_we=0 in every cycle without a W handshake.
- mem_addr shows the current word address in every state.
- mem_wdata and mem_wstrb pass WDATA/WSTRB through unconditionally.
- BVALID does not depend on BREADY. No combinational path exists from BREADY to AWREADY/WREADY.

## Timing
- Reset values while rst=1 and on the following cycle's registers:
  - state=IDLE, AWREADY=0 during rst, then 1 on the first cycle with rst=0.
  - WREADY=0, BVALID=0, BID=0, BRESP=0, mem_we=0, mem_addr=0, counter=0.
- AW handshake in cycle T → WREADY=1 from T+1.
- A W beat presented in the AW cycle is not accepted.
- Last W handshake in cycle L → BVALID=1 from L+1.
- BREADY=1 in cycle R → BVALID=0 and AWREADY=1 in R+1.
  - A new AWVALID is accepted in R+1 at the earliest.
  - If BREADY is already 1 when BVALID rises, B completes in that same cycle.
- Minimum transaction for a single beat is 3 cycles: AW, W, B.
- Throughput: one beat per cycle while WVALID stays high.
- AWLEN=4'hF gives 16 beats; the counter may reach 15 without overflow issues.
- rst asserted mid-burst or during RESP aborts immediately; no B is issued and no further mem_we occurs.

## Test plan
- Single write: AWID=8'h25, AWADDR=32'h0000_0010, AWLEN=0, WDATA=32'hDEAD_BEEF, WSTRB=4'hF, WLAST=1 → mem_we one cycle at mem_addr=4; next cycle BVALID=1, BID=8'h25, BRESP=2'b00.
- INCR burst: AWADDR=32'h0000_FFF8, AWLEN=3 (ADDR_W=14) → mem_addr 3FFE, 3FFF, 0000, 0001; BRESP=OKAY.
- FIXED burst with WVALID gaps and WSTRB=4'b0011: AWLEN=2 → three mem_we pulses, all at the same address, only on handshake cycles; mem_wstrb=4'b0011.
- Early WLAST on beat 2 of AWLEN=3 → two writes, BRESP=2'b10. Missing WLAST on beat 4 → four writes, BRESP=2'b10.
- B backpressure: BREADY low for 5 cycles → BVALID, BID and BRESP stay stable and AWREADY stays 0; after BREADY=1, AWREADY=1 the next cycle.
- rst pulse on the second beat of a 4-beat burst → no further mem_we and BVALID never rises. The next transaction completes normally.

Source files
------------

// File: rtl/axi_write_slave.sv
// AXI write-channel responder for a word-addressed SRAM port.
// Accepts one AW, the matching W burst, then returns a single B; one transaction at a time.
module axi_write_slave #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned IDS_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDS_W-1:0]  AWID,
    input  logic [31:0]       AWADDR,
    input  logic [3:0]        AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [IDS_W-1:0]  BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDS_W-1:0]    id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          len_q;
    logic [3:0]          cnt_q;
    logic                fixed_q;
    logic                err_q;

    logic aw_hs, w_hs, len_hit, last_beat;

    // Byte-offset and out-of-range address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[31:ADDR_W+2], AWADDR[1:0]};

    assign aw_hs     = AWVALID & AWREADY;
    assign w_hs      = WVALID & WREADY;
    assign len_hit   = (cnt_q == len_q);
    assign last_beat = WLAST | len_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            fixed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                id_q    <= AWID;
                addr_q  <= AWADDR[ADDR_W+1:2];
                len_q   <= AWLEN;
                fixed_q <= (AWBURST == 2'b00);
                cnt_q   <= '0;
                err_q   <= (AWSIZE != 3'b010);
            end
            if (w_hs) begin
                cnt_q <= cnt_q + 4'd1;
                if (!fixed_q) begin
                    addr_q <= addr_q + 1'b1;
                end
                // Terminating beat: WLAST and the beat count must agree.
                if (last_beat && (WLAST != len_hit)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        mem_we    = 1'b0;
        BID       = '0;
        BRESP     = 2'b00;
        mem_addr  = '0;
        mem_wdata = WDATA;
        mem_wstrb = WSTRB;
        // Handshake outputs are forced low while rst is held so an abort is immediate.
        if (!rst) begin
            BID      = id_q;
            BRESP    = err_q ? 2'b10 : 2'b00;
            mem_addr = addr_q;
            unique case (state_q)
                IDLE: begin
                    AWREADY = 1'b1;
                    if (AWVALID) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    WREADY = 1'b1;
                    mem_we = WVALID;
                    if (WVALID && last_beat) begin
                        state_d = RESP;
                    end
                end
                RESP: begin
                    BVALID = 1'b1;
                    if (BREADY) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_slave.sv
// Directed bench for axi_write_slave: single/INCR/FIXED bursts, WLAST errors, B backpressure, reset abort.
module tb_axi_write_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axi_write_slave #(.ADDR_W(14), .IDS_W(8)) dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        #2;
        chk("aw_ready", {31'd0, AWREADY}, 32'd1);
        chk("aw_wready_low", {31'd0, WREADY}, 32'd0);
        chk("aw_no_we", {31'd0, mem_we}, 32'd0);
        cyc();
        AWVALID = 1'b0;
    endtask

    task automatic wbeat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                         input logic [13:0] exp_addr);
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        #2;
        chk("w_ready", {31'd0, WREADY}, 32'd1);
        chk("w_we", {31'd0, mem_we}, 32'd1);
        chk("w_addr", {18'd0, mem_addr}, {18'd0, exp_addr});
        chk("w_data", mem_wdata, data);
        chk("w_strb", {28'd0, mem_wstrb}, {28'd0, strb});
        chk("w_awready_low", {31'd0, AWREADY}, 32'd0);
        cyc();
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic bresp(input logic [7:0] id, input logic [1:0] resp);
        #2;
        chk("b_valid", {31'd0, BVALID}, 32'd1);
        chk("b_id", {24'd0, BID}, {24'd0, id});
        chk("b_resp", {30'd0, BRESP}, {30'd0, resp});
        BREADY = 1'b1;
        cyc();
        BREADY = 1'b0;
        #2;
        chk("b_done_valid", {31'd0, BVALID}, 32'd0);
        chk("b_done_awready", {31'd0, AWREADY}, 32'd1);
    endtask

    initial begin
        logic [13:0] incr_addr [4];
        incr_addr[0] = 14'h3FFE; incr_addr[1] = 14'h3FFF; incr_addr[2] = 14'h0000; incr_addr[3] = 14'h0001;

        rst = 1'b1; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01;
        AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        #2;
        chk("rst_awready", {31'd0, AWREADY}, 32'd0);
        chk("rst_wready", {31'd0, WREADY}, 32'd0);
        chk("rst_bvalid", {31'd0, BVALID}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        cyc(); cyc();
        #2;
        chk("rst_bid", {24'd0, BID}, 32'd0);
        chk("rst_addr", {18'd0, mem_addr}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_awready", {31'd0, AWREADY}, 32'd1);
        chk("post_rst_bresp", {30'd0, BRESP}, 32'd0);
        cyc();

        // Single write; W presented together with AW must not be taken; BREADY pre-asserted.
        WVALID = 1'b1; WLAST = 1'b1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF;
        aw(8'h25, 32'h0000_0010, 4'd0, 3'b010, 2'b01);
        BREADY = 1'b1;
        wbeat(32'hDEAD_BEEF, 4'hF, 1'b1, 14'h0004);
        #2;
        chk("single_bvalid", {31'd0, BVALID}, 32'd1);
        chk("single_bid", {24'd0, BID}, 32'h25);
        chk("single_bresp", {30'd0, BRESP}, 32'd0);
        chk("single_no_we", {31'd0, mem_we}, 32'd0);
        cyc();
        BREADY = 1'b0;
        #2;
        chk("single_bdone", {31'd0, BVALID}, 32'd0);
        chk("single_awready", {31'd0, AWREADY}, 32'd1);

        // INCR burst wrapping the 14-bit word address space.
        aw(8'h11, 32'h0000_FFF8, 4'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) begin
            wbeat(32'h1000_0000 + 32'(i), 4'hF, (i == 3), incr_addr[i]);
        end
        bresp(8'h11, 2'b00);

        // FIXED burst with WVALID gaps.
        aw(8'h33, 32'h0000_0100, 4'd2, 3'b010, 2'b00);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("fixed_gap_we", {31'd0, mem_we}, 32'd0);
            chk("fixed_gap_wready", {31'd0, WREADY}, 32'd1);
            cyc();
            wbeat(32'hA5A5_0000 + 32'(i), 4'b0011, (i == 2), 14'h0040);
        end
        bresp(8'h33, 2'b00);

        // Early WLAST on beat 2 of 4.
        aw(8'h01, 32'h0000_0200, 4'd3, 3'b010, 2'b01);
        wbeat(32'h1, 4'hF, 1'b0, 14'h0080);
        wbeat(32'h2, 4'hF, 1'b1, 14'h0081);
        bresp(8'h01, 2'b10);

        // Missing WLAST on the 4th beat.
        aw(8'h02, 32'h0000_0300, 4'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) begin
            wbeat(32'h20 + 32'(i), 4'hF, 1'b0, 14'h00C0 + 14'(i));
        end
        bresp(8'h02, 2'b10);

        // B backpressure with stray AW/W traffic held off.
        aw(8'h3A, 32'h0000_0040, 4'd0, 3'b010, 2'b01);
        wbeat(32'hCAFE_F00D, 4'hF, 1'b1, 14'h0010);
        WVALID = 1'b1; AWVALID = 1'b1; AWID = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("bp_bvalid", {31'd0, BVALID}, 32'd1);
            chk("bp_bid", {24'd0, BID}, 32'h3A);
            chk("bp_bresp", {30'd0, BRESP}, 32'd0);
            chk("bp_awready", {31'd0, AWREADY}, 32'd0);
            chk("bp_wready", {31'd0, WREADY}, 32'd0);
            chk("bp_we", {31'd0, mem_we}, 32'd0);
            cyc();
        end
        WVALID = 1'b0; AWVALID = 1'b0;
        bresp(8'h3A, 2'b00);

        // Reset on the second beat of a 4-beat burst.
        aw(8'h05, 32'h0000_0000, 4'd3, 3'b010, 2'b01);
        wbeat(32'h50, 4'hF, 1'b0, 14'h0000);
        rst = 1'b1; WVALID = 1'b1;
        #2;
        chk("abort_we", {31'd0, mem_we}, 32'd0);
        chk("abort_wready", {31'd0, WREADY}, 32'd0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("abort_after_we", {31'd0, mem_we}, 32'd0);
            chk("abort_after_bvalid", {31'd0, BVALID}, 32'd0);
            chk("abort_after_addr", {18'd0, mem_addr}, 32'd0);
            cyc();
        end
        WVALID = 1'b0;

        // Normal transaction after the abort.
        aw(8'h06, 32'h0000_0008, 4'd0, 3'b010, 2'b01);
        wbeat(32'h6666_6666, 4'b1000, 1'b1, 14'h0002);
        bresp(8'h06, 2'b00);

        // Illegal AWSIZE reports SLVERR.
        aw(8'h07, 32'h0000_000C, 4'd0, 3'b011, 2'b01);
        wbeat(32'h7, 4'hF, 1'b1, 14'h0003);
        bresp(8'h07, 2'b10);

        // 16-beat burst exercises the full counter range.
        aw(8'h08, 32'h0000_0400, 4'hF, 3'b010, 2'b10);
        for (int i = 0; i < 16; i++) begin
            wbeat(32'h800 + 32'(i), 4'hF, (i == 15), 14'h0100 + 14'(i));
        end
        bresp(8'h08, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish by 200000");
        $fatal(1);
    end

endmodule
